mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 7, word-address width of the shared memory.
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Parameter STARVE_MAX, 4, consecutive denied fetch cycles before fetch overrides data port (range 1..15).
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports ld_req/ld_addr/ld_wdata  in  1/ADDR_W/DATA_W  loader write request; ld_gnt  out  1.
REQ-007 Ports if_req/if_addr  in  1/ADDR_W  fetch read request; if_gnt, if_rvalid  out  1; if_rdata  out  DATA_W.
REQ-008 Ports dm_req/dm_we/dm_addr/dm_wdata  in  1/1/ADDR_W/DATA_W  data-stage access; dm_gnt, dm_rvalid  out  1; dm_rdata  out  DATA_W.
REQ-009 Ports mem_en/mem_we/mem_addr/mem_wdata  out  1/1/ADDR_W/DATA_W; mem_rdata  in  DATA_W  single-port synchronous memory, 1-cycle read latency.
REQ-010 Ports stall_if, core_restart  out  1  fetch stall; one-cycle pipeline restart pulse.

Function
REQ-011 FSM states RUN, LOAD, DRAIN; RUN->LOAD when ld_req=1; LOAD->DRAIN when ld_req=0; DRAIN->RUN unconditionally after one cycle.
REQ-012 In LOAD: ld_gnt=ld_req, mem_en=mem_we=ld_req, mem_addr=ld_addr, mem_wdata=ld_wdata; if_gnt=dm_gnt=0; stall_if=1.
REQ-013 In DRAIN: no grants, mem_en=0, stall_if=1, core_restart=1 for exactly that cycle.
REQ-014 In RUN: grants combinational, at most one per cycle; dm wins over if unless starve_cnt==STARVE_MAX, in which case if wins.
REQ-015 In RUN, ld_req=1 grants nothing that cycle; transition to LOAD takes effect next cycle.
REQ-016 starve_cnt (4-bit, saturating at STARVE_MAX) increments each RUN cycle with if_req=1 and if_gnt=0; clears on if_gnt or if_req=0.
REQ-017 stall_if = if_req & ~if_gnt in RUN.
REQ-018 Granted request drives mem_en=1, mem_addr, mem_we (dm_we for data, 0 for fetch), mem_wdata=dm_wdata.
REQ-019 Read grant -> requester's rvalid=1 exactly one cycle later with rdata=mem_rdata; writes produce no rvalid.
REQ-020 rdata outputs hold last returned value when rvalid=0.
REQ-021 Read issued in the cycle before ld_req still returns its rvalid in LOAD.

Reset
REQ-022 rst_n=0 forces state RUN, starve_cnt=0, rvalid pipeline cleared, rdata=0, all grants/mem_en/core_restart=0, stall_if=0; takes effect immediately, asynchronously.
REQ-023 Reset mid-LOAD abandons the load; no core_restart pulse issued.

Configuration
REQ-024 Macro MEM_ARBITER_STATS_EN defined: add outputs stat_if_stall (16-bit, counts stall_if cycles in RUN) and stat_dm_ops (16-bit, counts dm grants), both saturating, reset to 0.
REQ-025 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-026 Shared package mem_arb_pkg holds FSM state enum (RUN, LOAD, DRAIN), requester-id encoding, and default widths.
REQ-027 One sub-module mem_arb_starve (starvation counter + override flag); everything else in mem_arbiter.

Verification
REQ-028 if_req and dm_req both high with STARVE_MAX=4: dm granted cycles 0-3, if granted cycle 4, starve_cnt then 0.
REQ-029 if read addr 5 with mem[5]=0x1234: if_rvalid=1, if_rdata=0x1234 the next cycle; no dm_rvalid.
REQ-030 ld_req high 3 cycles writing addr 0..2: mem_we=1 each LOAD cycle, if_gnt=0; DRAIN then core_restart=1 for one cycle; RUN.
REQ-031 dm write addr 13 data 7: mem_we=1, dm_gnt=1, no dm_rvalid next cycle.
REQ-032 rst_n low during LOAD: outputs zero immediately; after release state RUN, core_restart stays 0.
REQ-033 STATS_EN build: 10 stalled fetch cycles -> stat_if_stall=10.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM states, requester ids and
// default widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;
    localparam int STARVE_CNT_W   = 4;
    localparam int STAT_W         = 16;

    // Arbiter operating mode
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Which requester owns the memory port this cycle
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_LD   = 2'd1,
        REQ_IF   = 2'd2,
        REQ_DM   = 2'd3
    } req_id_e;

endpackage

// File: rtl/mem_arb_starve.sv
// Fetch starvation tracker: counts consecutive RUN cycles in which fetch asks
// but is refused, saturating at STARVE_MAX. The override flag lets fetch beat
// the data port once the count reaches the limit.
module mem_arb_starve
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_if_req,
    input  logic i_if_gnt,
    output logic o_override
);

    localparam logic [STARVE_CNT_W-1:0] LP_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Count refused fetch cycles while running; any grant or idle fetch clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_run) begin
            if (i_if_req && !i_if_gnt) begin
                if (r_cnt < LP_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_override = (r_cnt == LP_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by a program loader, instruction fetch
// and the data stage. While the loader is active the core is held off; once
// the load ends a one-cycle DRAIN state pulses core_restart.
// Optional build macro MEM_ARBITER_STATS_EN adds saturating stall/op counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              core_restart
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_if_stall,
    output logic [STAT_W-1:0] stat_dm_ops
`endif
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    req_id_e           w_owner;
    logic              w_override;
    logic              r_if_vld_p1;
    logic              r_dm_vld_p1;
    logic [DATA_W-1:0] r_if_rdata_hold;
    logic [DATA_W-1:0] r_dm_rdata_hold;

    mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_run      (r_state == RUN),
        .i_if_req   (if_req),
        .i_if_gnt   (if_gnt),
        .o_override (w_override)
    );

    // Mode register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mode sequencing: a load request moves to LOAD next cycle, the end of
    // the burst passes through a single DRAIN cycle back to RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (ld_req)  w_state_nxt = LOAD;
            LOAD:    if (!ld_req) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Pick the owner of the memory port; everything is held off while in
    // reset so the outputs drop the moment rst_n falls
    always_comb begin
        w_owner      = REQ_NONE;
        stall_if     = 1'b0;
        core_restart = 1'b0;
        if (rst_n) begin
            case (r_state)
                RUN: begin
                    // A pending load request blocks all grants this cycle
                    if (!ld_req) begin
                        if (if_req && (!dm_req || w_override)) begin
                            w_owner = REQ_IF;
                        end else if (dm_req) begin
                            w_owner = REQ_DM;
                        end
                    end
                    stall_if = if_req && (w_owner != REQ_IF);
                end
                LOAD: begin
                    stall_if = 1'b1;
                    if (ld_req) begin
                        w_owner = REQ_LD;
                    end
                end
                DRAIN: begin
                    stall_if     = 1'b1;
                    core_restart = 1'b1;
                end
                default: begin
                    w_owner = REQ_NONE;
                end
            endcase
        end
    end

    // Drive grants and the memory port from the chosen owner
    always_comb begin
        ld_gnt    = (w_owner == REQ_LD);
        if_gnt    = (w_owner == REQ_IF);
        dm_gnt    = (w_owner == REQ_DM);
        mem_en    = (w_owner != REQ_NONE);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (w_owner)
            REQ_LD: begin
                mem_we    = 1'b1;
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
            end
            REQ_IF: begin
                mem_addr  = if_addr;
                mem_wdata = dm_wdata;
            end
            REQ_DM: begin
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Read-return tracking: memory answers one cycle after the grant, and
    // this path ignores the mode so reads in flight at LOAD entry complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_vld_p1 <= 1'b0;
            r_dm_vld_p1 <= 1'b0;
        end else begin
            r_if_vld_p1 <= if_gnt;
            r_dm_vld_p1 <= dm_gnt && !dm_we;
        end
    end

    // Capture returned words so rdata holds steady between returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rdata_hold <= '0;
            r_dm_rdata_hold <= '0;
        end else begin
            if (r_if_vld_p1) r_if_rdata_hold <= mem_rdata;
            if (r_dm_vld_p1) r_dm_rdata_hold <= mem_rdata;
        end
    end

    assign if_rvalid = r_if_vld_p1;
    assign dm_rvalid = r_dm_vld_p1;
    assign if_rdata  = r_if_vld_p1 ? mem_rdata : r_if_rdata_hold;
    assign dm_rdata  = r_dm_vld_p1 ? mem_rdata : r_dm_rdata_hold;

`ifdef MEM_ARBITER_STATS_EN
    logic [STAT_W-1:0] r_stat_if_stall;
    logic [STAT_W-1:0] r_stat_dm_ops;

    // Saturating counters of fetch stalls in RUN and data-port grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_if_stall <= '0;
            r_stat_dm_ops   <= '0;
        end else begin
            if ((r_state == RUN) && stall_if && (r_stat_if_stall != '1)) begin
                r_stat_if_stall <= r_stat_if_stall + 1'b1;
            end
            if (dm_gnt && (r_stat_dm_ops != '1)) begin
                r_stat_dm_ops <= r_stat_dm_ops + 1'b1;
            end
        end
    end

    assign stat_if_stall = r_stat_if_stall;
    assign stat_dm_ops   = r_stat_dm_ops;
`endif

endmodule
